// File: rtl/lcd_pattern_gen_if.sv
// lcd_pattern_gen_if: timing-generator strobes in, RGB565 pixel bus out
interface lcd_pattern_gen_if;
  logic       de_in;
  logic       vsync_in;
  logic [4:0] LCD_R;
  logic [5:0] LCD_G;
  logic [4:0] LCD_B;
  modport master (output de_in, vsync_in, input LCD_R, LCD_G, LCD_B);
  modport slave (input de_in, vsync_in, output LCD_R, LCD_G, LCD_B);
endinterface

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: RGB565 test-pattern source paced by the pixel clock, button-selected pattern
module lcd_pattern_gen #(
  parameter int H_ACTIVE      = 480,
  parameter int V_ACTIVE      = 272,
  parameter int BAR_W         = 60,
  parameter int VS_ACTIVE_LOW = 1,
  parameter int DEB_CYCLES    = 900000
) (
  input  logic              CLK_SYS,
  input  logic              rst,
  input  logic              PixelClk,
  input  logic              mode_btn_n,
  lcd_pattern_gen_if.slave  bus,
  output logic [1:0]        mode,
  output logic              frame_tick
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int BW = $clog2(BAR_W);
  localparam logic [8:0] X_MAX = 9'(H_ACTIVE - 1);
  localparam logic [8:0] Y_MAX = 9'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_MAX = BW'(BAR_W - 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_HIT = CW'(DEB_CYCLES - 1);

  logic [1:0]    clk_s, de_s, vs_s, btn_s;
  logic          clk_h, de_h, vs_h;
  logic          pix_ce, vs_on, vs_was, frame_start;
  logic [8:0]    x, y;
  logic [2:0]    bar;
  logic [BW-1:0] bar_cnt;
  logic [15:0]   rgb, pix;
  logic [1:0]    pending;
  logic          btn_l, deb, stable, deb_hit, press;
  logic [CW-1:0] deb_cnt;

  assign pix_ce      = clk_s[1] & ~clk_h;
  assign vs_on       = (VS_ACTIVE_LOW != 0) ? ~vs_s[1] : vs_s[1];
  assign vs_was      = (VS_ACTIVE_LOW != 0) ? ~vs_h : vs_h;
  assign frame_start = pix_ce & vs_on & ~vs_was;
  assign stable      = btn_s[1] == btn_l;
  assign deb_hit     = stable && deb_cnt == DEB_HIT;
  assign press       = deb_hit & deb & ~btn_s[1];
  assign bus.LCD_R   = rgb[15:11];
  assign bus.LCD_G   = rgb[10:5];
  assign bus.LCD_B   = rgb[4:0];

  // two-flop synchronisers; the clock history flop runs every cycle to make the edge strobe
  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      clk_s <= '0;
      de_s  <= '0;
      vs_s  <= '0;
      btn_s <= 2'b11;
      clk_h <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], PixelClk};
      de_s  <= {de_s[0], bus.de_in};
      vs_s  <= {vs_s[0], bus.vsync_in};
      btn_s <= {btn_s[0], mode_btn_n};
      clk_h <= clk_s[1];
    end
  end

  // pattern colour for the current coordinate; bar colour bits decode straight from the index
  always_comb begin
    pix = mode == 2'd0 ? {{5{~bar[1]}}, {6{~bar[2]}}, {5{~bar[0]}}} :
          mode == 2'd1 ? {x[8:4], x[8:3], ~x[8:4]} :
          mode == 2'd2 ? ((x[4] ^ y[4]) ? 16'hFFFF : 16'h0000) :
          (x[3:0] == 4'd0 || y[3:0] == 4'd0 || x == X_MAX || y == Y_MAX) ? 16'hFFFF : 16'h001F;
  end

  // coordinate tracking, frame-boundary mode switch and registered RGB, all on pix_ce
  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      de_h       <= 1'b0;
      vs_h       <= 1'b0;
      x          <= '0;
      y          <= '0;
      bar        <= '0;
      bar_cnt    <= '0;
      mode       <= '0;
      frame_tick <= 1'b0;
      rgb        <= '0;
    end else begin
      frame_tick <= frame_start;
      if (pix_ce) begin
        de_h <= de_s[1];
        vs_h <= vs_s[1];
        rgb  <= de_s[1] ? pix : 16'h0000;
        if (frame_start) begin
          x       <= '0;
          y       <= '0;
          bar     <= '0;
          bar_cnt <= '0;
          mode    <= pending;
        end else if (de_s[1]) begin
          x       <= x == X_MAX ? x : x + 9'd1;
          bar_cnt <= bar_cnt == BAR_MAX ? '0 : bar_cnt + 1'b1;
          bar     <= (bar_cnt == BAR_MAX && bar != 3'd7) ? bar + 3'd1 : bar;
        end else if (de_h) begin
          x       <= '0;
          bar     <= '0;
          bar_cnt <= '0;
          y       <= y == Y_MAX ? y : y + 9'd1;
        end
      end
    end
  end

  // button debounce: counter restarts on every level change, a settled press bumps pending
  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      btn_l   <= 1'b1;
      deb     <= 1'b1;
      deb_cnt <= '0;
      pending <= '0;
    end else begin
      btn_l   <= btn_s[1];
      deb_cnt <= stable ? (deb_cnt == DEB_MAX ? deb_cnt : deb_cnt + 1'b1) : '0;
      if (deb_hit) deb <= btn_s[1];
      if (press) pending <= pending + 2'd1;
    end
  end
endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb_lcd_pattern_gen: directed checks of pacing, patterns, line/frame tracking, debounce and reset
module tb_lcd_pattern_gen;
  logic        clk = 1'b0, rst = 1'b0, pclk = 1'b0, btn = 1'b1;
  logic [1:0]  mode;
  logic        frame_tick;
  logic [15:0] rgb;
  int          checks = 0, errors = 0, ticks = 0, n = 0;

  lcd_pattern_gen_if bus ();

  lcd_pattern_gen #(.DEB_CYCLES(40)) dut (
    .CLK_SYS    (clk),
    .rst        (rst),
    .PixelClk   (pclk),
    .mode_btn_n (btn),
    .bus        (bus),
    .mode       (mode),
    .frame_tick (frame_tick)
  );

  assign rgb = {bus.LCD_R, bus.LCD_G, bus.LCD_B};

  always #5 clk = ~clk;
  always #50 pclk = ~pclk;
  always @(posedge clk) if (frame_tick) ticks++;

  initial begin
    #3000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one pixel period: drive strobes on the PixelClk rise, return once that pixel's RGB is out
  task automatic px(input logic d, input logic v);
    @(posedge pclk);
    bus.de_in    = d;
    bus.vsync_in = v;
    #30;
  endtask

  task automatic frame();
    px(1'b0, 1'b0);
    px(1'b0, 1'b1);
  endtask

  task automatic press();
    btn = 1'b0;
    repeat (100) @(negedge clk);
    btn = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  initial begin
    bus.de_in    = 1'b0;
    bus.vsync_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_rgb", rgb, 16'h0000);
    chk("rst_mode", 16'(mode), 16'd0);
    chk("rst_tick", 16'(frame_tick), 16'd0);
    rst = 1'b1;
    repeat (3) px(1'b0, 1'b1);
    frame();
    chk("tick_count", 16'(ticks), 16'd1);
    chk("tick_low", 16'(frame_tick), 16'd0);
    repeat (200) begin
      @(posedge clk);
      n += int'(dut.pix_ce);
    end
    chk("pix_ce_rate", 16'(n), 16'd20);
    for (int k = 0; k < 480; k++) begin
      px(1'b1, 1'b1);
      if (k == 0) chk("x_step1", 16'(dut.x), 16'd1);
      if (k == 1) chk("x_step2", 16'(dut.x), 16'd2);
      if (k == 0 || k == 59) chk("bar_white", rgb, 16'hFFFF);
      if (k == 60 || k == 119) chk("bar_yellow", rgb, 16'hFFE0);
      if (k == 180) chk("bar_green", rgb, 16'h07E0);
      if (k == 240) chk("bar_magenta", rgb, 16'hF81F);
      if (k == 420 || k == 479) chk("bar_black", rgb, 16'h0000);
    end
    chk("x_at_end", 16'(dut.x), 16'd479);
    repeat (3) px(1'b1, 1'b1);
    chk("x_sat", 16'(dut.x), 16'd479);
    px(1'b0, 1'b1);
    chk("y_line1", 16'(dut.y), 16'd1);
    chk("x_line_rst", 16'(dut.x), 16'd0);
    px(1'b1, 1'b1);
    chk("line2_white", rgb, 16'hFFFF);
    px(1'b0, 1'b1);
    chk("rgb_off", rgb, 16'h0000);
    px(1'b1, 1'b1);
    px(1'b0, 1'b1);
    chk("y_three", 16'(dut.y), 16'd3);
    frame();
    chk("tick_count2", 16'(ticks), 16'd2);
    chk("frame_x", 16'(dut.x), 16'd0);
    chk("frame_y", 16'(dut.y), 16'd0);
    for (int k = 0; k < 300; k++) begin
      px(1'b1, 1'b1);
      px(1'b0, 1'b1);
    end
    chk("y_sat", 16'(dut.y), 16'd271);
    repeat (3) begin
      btn = 1'b0;
      repeat (5) @(negedge clk);
      btn = 1'b1;
      repeat (10) @(negedge clk);
    end
    repeat (60) @(negedge clk);
    frame();
    chk("glitch_mode", 16'(mode), 16'd0);
    press();
    chk("mode_before_frame", 16'(mode), 16'd0);
    frame();
    chk("mode_1", 16'(mode), 16'd1);
    for (int k = 0; k < 17; k++) begin
      px(1'b1, 1'b1);
      if (k == 16) chk("grad_x16", rgb, 16'h085E);
    end
    px(1'b0, 1'b1);
    press();
    frame();
    chk("mode_2", 16'(mode), 16'd2);
    for (int k = 0; k < 17; k++) begin
      px(1'b1, 1'b1);
      if (k == 0) chk("chk_x0_y0", rgb, 16'h0000);
      if (k == 16) chk("chk_x16_y0", rgb, 16'hFFFF);
    end
    px(1'b0, 1'b1);
    repeat (15) begin
      px(1'b1, 1'b1);
      px(1'b0, 1'b1);
    end
    for (int k = 0; k < 17; k++) begin
      px(1'b1, 1'b1);
      if (k == 0) chk("chk_x0_y16", rgb, 16'hFFFF);
      if (k == 16) chk("chk_x16_y16", rgb, 16'h0000);
    end
    px(1'b0, 1'b1);
    press();
    frame();
    chk("mode_3", 16'(mode), 16'd3);
    px(1'b1, 1'b1);
    chk("grid_x0_y0", rgb, 16'hFFFF);
    px(1'b0, 1'b1);
    px(1'b1, 1'b1);
    chk("grid_x0_y1", rgb, 16'hFFFF);
    px(1'b1, 1'b1);
    chk("grid_x1_y1", rgb, 16'h001F);
    px(1'b0, 1'b1);
    press();
    frame();
    chk("mode_wrap", 16'(mode), 16'd0);
    press();
    frame();
    chk("mode_1_again", 16'(mode), 16'd1);
    px(1'b1, 1'b1);
    px(1'b1, 1'b1);
    chk("pre_reset_rgb", rgb, 16'h001F);
    #5;
    rst = 1'b0;
    #1;
    chk("async_rgb", rgb, 16'h0000);
    chk("async_mode", 16'(mode), 16'd0);
    chk("async_x", 16'(dut.x), 16'd0);
    chk("async_y", 16'(dut.y), 16'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    px(1'b1, 1'b1);
    px(1'b1, 1'b1);
    chk("post_reset_x", 16'(dut.x), 16'd2);
    px(1'b0, 1'b1);
    frame();
    px(1'b1, 1'b1);
    chk("bars_resume", rgb, 16'hFFFF);
    chk("bars_mode", 16'(mode), 16'd0);
    px(1'b0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
